// File: rtl/wseq_pkg.sv
// wseq_pkg: uCode field layout, per-layer Mode one-hots, layer and state encodings
// shared by the weights fetch sequencer and its address counter.
package wseq_pkg;
    localparam int WIDTH_MSB = 14;
    localparam int DEPTH_MSB = 10;
    localparam int MODE_MSB  = 5;
    localparam int EN_BIT    = 0;

    localparam logic [4:0] MODE_CONV1 = 5'b10000;
    localparam logic [4:0] MODE_CONV2 = 5'b01000;
    localparam logic [4:0] MODE_CONV3 = 5'b00100;
    localparam logic [4:0] MODE_FC1   = 5'b00010;
    localparam logic [4:0] MODE_FC2   = 5'b00001;

    typedef enum logic [2:0] {
        L_CONV1 = 3'd0,
        L_CONV2 = 3'd1,
        L_CONV3 = 3'd2,
        L_FC1   = 3'd3,
        L_FC2   = 3'd4
    } layer_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    function automatic logic [4:0] layer_mode(input layer_e l);
        return l == L_CONV1 ? MODE_CONV1 :
               l == L_CONV2 ? MODE_CONV2 :
               l == L_CONV3 ? MODE_CONV3 :
               l == L_FC1   ? MODE_FC1   : MODE_FC2;
    endfunction

    function automatic logic [14:0] pack_ucode(input logic [3:0] w, input logic [4:0] d,
                                               input logic [4:0] mode, input logic en);
        logic [14:0] u;
        u = '0;
        u[WIDTH_MSB -: 4] = w;
        u[DEPTH_MSB -: 5] = d;
        u[MODE_MSB -: 5]  = mode;
        u[EN_BIT]         = en;
        return u;
    endfunction
endpackage

// File: rtl/wseq_addr_counter.sv
// wseq_addr_counter: nested depth/width address counter, width is the inner loop.
// Holds on the final (d_max, w_max) word so full 32-deep / 16-wide layers never wrap.
module wseq_addr_counter
    import wseq_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_step,
    input  logic       i_clear,
    input  logic [4:0] i_d_max,
    input  logic [3:0] i_w_max,
    output logic [4:0] o_d,
    output logic [3:0] o_w,
    output logic       o_last
);
    logic [4:0] r_d;
    logic [3:0] r_w;

    assign o_d    = r_d;
    assign o_w    = r_w;
    assign o_last = r_d == i_d_max && r_w == i_w_max;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_d <= '0;
            r_w <= '0;
        end else if (i_clear) begin
            r_d <= '0;
            r_w <= '0;
        end else if (i_step && !o_last) begin
            r_w <= r_w == i_w_max ? 4'd0 : r_w + 4'd1;
            if (r_w == i_w_max)
                r_d <= r_d + 5'd1;
        end
    end
endmodule

// File: rtl/weights_fetch_sequencer.sv
// weights_fetch_sequencer: walks a layer's weight RAM address space and drives the RAM uCode bus.
// With WSEQ_AUTO_CHAIN_EN defined, one Start runs from the selected layer through FC_2nd.
module weights_fetch_sequencer
    import wseq_pkg::*;
#(
    parameter int CONV1_DEPTH = 16,
    parameter int CONV1_WIDTH = 1,
    parameter int CONV2_DEPTH = 16,
    parameter int CONV2_WIDTH = 16,
    parameter int CONV3_DEPTH = 16,
    parameter int CONV3_WIDTH = 16,
    parameter int FC1_DEPTH   = 32,
    parameter int FC1_WIDTH   = 16,
    parameter int FC2_DEPTH   = 1,
    parameter int FC2_WIDTH   = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_layer_sel,
    input  logic        i_abort,
    input  logic        i_step_ready,
    output logic [14:0] o_ucode,
    output logic        o_data_valid,
    output logic        o_data_last,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);
    state_e     r_state;
    layer_e     r_layer;
    logic [4:0] r_mode;
    logic       r_en;
    logic       r_valid;
    logic       r_last;
    logic       r_done;
    logic       r_err;
    logic [4:0] w_d;
    logic [4:0] w_d_max;
    logic [3:0] w_w;
    logic [3:0] w_w_max;
    logic       w_last;
    logic       w_step;
    logic       w_clear;

    assign w_d_max = r_layer == L_CONV1 ? 5'(CONV1_DEPTH - 1) :
                     r_layer == L_CONV2 ? 5'(CONV2_DEPTH - 1) :
                     r_layer == L_CONV3 ? 5'(CONV3_DEPTH - 1) :
                     r_layer == L_FC1   ? 5'(FC1_DEPTH - 1)   : 5'(FC2_DEPTH - 1);
    assign w_w_max = r_layer == L_CONV1 ? 4'(CONV1_WIDTH - 1) :
                     r_layer == L_CONV2 ? 4'(CONV2_WIDTH - 1) :
                     r_layer == L_CONV3 ? 4'(CONV3_WIDTH - 1) :
                     r_layer == L_FC1   ? 4'(FC1_WIDTH - 1)   : 4'(FC2_WIDTH - 1);

    assign w_step  = r_state == S_RUN && i_step_ready && !i_abort;
    assign w_clear = r_state != S_RUN || i_abort;

    wseq_addr_counter u_addr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_step  (w_step),
        .i_clear (w_clear),
        .i_d_max (w_d_max),
        .i_w_max (w_w_max),
        .o_d     (w_d),
        .o_w     (w_w),
        .o_last  (w_last)
    );

    assign o_ucode      = pack_ucode(w_w, w_d, r_mode, r_en);
    assign o_data_valid = r_valid;
    assign o_data_last  = r_last;
    assign o_busy       = r_state != S_IDLE;
    assign o_done       = r_done;
    assign o_err        = r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_layer <= L_CONV1;
            r_mode  <= '0;
            r_en    <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_step;
            r_last  <= w_step && w_last;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            if (i_abort) begin
                r_state <= S_IDLE;
                r_mode  <= '0;
                r_en    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (i_start) begin
                        if (i_layer_sel <= L_FC2) begin
                            r_layer <= layer_e'(i_layer_sel);
                            r_mode  <= layer_mode(layer_e'(i_layer_sel));
                            r_en    <= 1'b1;
                            r_state <= S_RUN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    S_RUN: if (w_step && w_last) r_state <= S_DRAIN;
                    S_DRAIN:
`ifdef WSEQ_AUTO_CHAIN_EN
                        if (r_layer != L_FC2) begin
                            r_layer <= layer_e'(r_layer + 3'd1);
                            r_mode  <= r_mode >> 1;
                            r_state <= S_RUN;
                        end else
`endif
                        begin
                            r_done  <= 1'b1;
                            r_mode  <= '0;
                            r_en    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
